// File: rtl/multibyte_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multibyte_add_seq_pkg
//  Purpose  : Shared definitions for the byte-serial multi-precision adder.
//             - FSM state encoding for the sequencer
//             - Byte width of the shared adder datapath
//  Revision : 1.0  - initial release
// ============================================================================
package multibyte_add_seq_pkg;

  // Width of one adder slice; the whole datapath is built around it.
  localparam int BYTE_W = 8;

  // Sequencer states. Encoding is fixed so that it stays stable across
  // revisions and in debug dumps; the value 2'd3 is never entered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : multibyte_add_seq_pkg
`default_nettype wire

// File: rtl/multibyte_add_seq_adder8bit.sv
`default_nettype none
// ============================================================================
//  Module   : adder8Bit
//  Purpose  : Purely combinational 8-bit adder with carry-in and carry-out.
//             This is the existing byte adder reused by the sequencer.
//  Ports    : Cin  in   1  carry-in
//             A    in   8  operand A
//             B    in   8  operand B
//             Cout out  1  carry-out of bit 7
//             S    out  8  sum bits
//  Revision : 1.0  - initial release
// ============================================================================
module adder8Bit (
  input  logic       Cin,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       Cout,
  output logic [7:0] S
);

  // Zero-extend to 9 bits so the carry out appears as the top bit.
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule : adder8Bit
`default_nettype wire

// File: rtl/multibyte_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : multibyte_add_seq
//  Purpose  : Byte-serial multi-precision adder controller. Latches two
//             NBYTES-wide operands plus a carry-in on start, then walks a
//             single shared adder8Bit across the bytes, least-significant
//             byte first, chaining the carry through a register. Presents the
//             wide sum, carry-out and signed overflow with a one-cycle done.
//  Ports    : clk       in   1  system clock, rising edge
//             reset     in   1  asynchronous active-high reset
//             start     in   1  operation request, sampled only in IDLE
//             cin       in   1  carry-in for byte 0, latched with start
//             a         in   W  operand A, latched with start
//             b         in   W  operand B, latched with start
//             busy      out  1  high while bytes are being processed
//             done      out  1  one-cycle pulse, result valid
//             sum       out  W  result, held until the next accepted start
//             cout      out  1  carry out of the most significant byte
//             overflow  out  1  two's-complement overflow of the W-bit add
//  Revision : 1.0  - initial release
// ============================================================================
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  // Derived; leave at default.
  parameter int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       cin,
  input  logic [BYTE_W*NBYTES-1:0]   a,
  input  logic [BYTE_W*NBYTES-1:0]   b,
  output logic                       busy,
  output logic                       done,
  output logic [BYTE_W*NBYTES-1:0]   sum,
  output logic                       cout,
  output logic                       overflow
);

  localparam int W = BYTE_W * NBYTES;
  // Byte index at which the operation completes (0 when NBYTES == 1).
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   idx;
  logic              carry_reg;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      sum_reg;
  logic              cout_reg;
  logic              ovf_reg;

  // --------------------------------------------------------------------------
  // Byte selection. A shift by idx*8 is used instead of an indexed
  // part-select so the selector width follows IDXW exactly.
  // --------------------------------------------------------------------------
  logic [IDXW+2:0]   byte_shamt;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] add_s;
  logic              add_cout;
  logic              last_byte;
  logic              byte_ovf;
  logic [W-1:0]      sum_merged;

  assign byte_shamt = {idx, 3'b000};
  assign a_byte     = BYTE_W'(a_reg >> byte_shamt);
  assign b_byte     = BYTE_W'(b_reg >> byte_shamt);
  assign last_byte  = (idx == LAST_IDX);

  // Signed overflow of the full-width add depends only on the top byte:
  // like-signed operands producing a result of the opposite sign.
  assign byte_ovf   = (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                      (add_s[BYTE_W-1] != a_byte[BYTE_W-1]);

  // Replace only the byte currently being processed; the other bytes keep
  // whatever earlier cycles (or the previous operation) left there.
  assign sum_merged = (sum_reg & ~(W'({BYTE_W{1'b1}}) << byte_shamt)) |
                      (W'(add_s) << byte_shamt);

  // --------------------------------------------------------------------------
  // Shared byte adder
  // --------------------------------------------------------------------------
  adder8Bit u_adder (
    .Cin  (carry_reg),
    .A    (a_byte),
    .B    (b_byte),
    .Cout (add_cout),
    .S    (add_s)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. start is only looked at in IDLE, so a request
  // that stays high across RUN/DONE simply starts one further operation
  // once the sequencer is idle again.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (last_byte) state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, byte index, carry chain and results
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
          end
        end
        ST_RUN: begin
          sum_reg   <= sum_merged;
          carry_reg <= add_cout;
          if (last_byte) begin
            cout_reg <= add_cout;
            ovf_reg  <= byte_ovf;
            idx      <= '0;
          end else begin
            idx      <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded directly from registered state, no input-to-output path
  // --------------------------------------------------------------------------
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule : multibyte_add_seq
`default_nettype wire

// File: tb/tb_multibyte_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multibyte_add_seq
//  Purpose  : Self-checking bench for multibyte_add_seq (NBYTES = 4).
//             Expected results come from plain full-width arithmetic.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  // Reference: {overflow, cout, sum} of a + b + cin, straight arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         ci);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full};
  endfunction

  // Launch one operation from IDLE and watch it to completion.
  // done_cyc: index of the negedge (counted from the start edge) where done
  // was seen, 0 on timeout. done_after: done level one cycle later.
  task automatic do_op(input  logic [W-1:0] xa, input logic [W-1:0] xb,
                       input  logic         xc,
                       output logic [W-1:0] r_sum, output logic r_cout,
                       output logic         r_ovf, output int busy_cnt,
                       output int           done_cyc, output logic done_after);
    r_sum = '0; r_cout = 1'b0; r_ovf = 1'b0; busy_cnt = 0; done_cyc = 0;
    done_after = 1'bx;
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom(); b = $urandom(); cin = $urandom_range(0, 1);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = i;
        r_sum = sum; r_cout = cout; r_ovf = overflow;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7];
    logic [W-1:0] tb [7];
    logic         tc [7];
    logic [W-1:0] gs; logic gc, go, da; int bc, dc;
    logic [W+1:0] e;
    ta = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00FFFFFF,
           32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    tb = '{32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
           32'h00000001, 32'h80000000, 32'hEDCBA987};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      do_op(ta[k], tb[k], tc[k], gs, gc, go, bc, dc, da);
      e = ref_add(ta[k], tb[k], tc[k]);
      n_checks++; if (dc !== NBYTES + 1) begin n_fail++; $display("FAIL dir_done_latency[%0d]: got %0d expected %0d", k, dc, NBYTES + 1); end
      n_checks++; if (bc !== NBYTES) begin n_fail++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", k, bc, NBYTES); end
      n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse[%0d]: done still %b one cycle later, expected 0", k, da); end
      n_checks++; if (gs !== e[W-1:0]) begin n_fail++; $display("FAIL dir_sum[%0d]: got %h expected %h", k, gs, e[W-1:0]); end
      n_checks++; if (gc !== e[W]) begin n_fail++; $display("FAIL dir_cout[%0d]: got %b expected %b", k, gc, e[W]); end
      n_checks++; if (go !== e[W+1]) begin n_fail++; $display("FAIL dir_ovf[%0d]: got %b expected %b", k, go, e[W+1]); end
    end
    // sum must hold after done until the next start
    n_checks++; if (sum !== gs) begin n_fail++; $display("FAIL dir_sum_hold: got %h expected %h", sum, gs); end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    logic [W-1:0] xa, xb, gs; logic xc, gc, go, da; int bc, dc;
    logic [W+1:0] e;
    for (int k = 0; k < 25; k++) begin
      xa = pick_operand(); xb = pick_operand(); xc = 1'($urandom_range(0, 1));
      do_op(xa, xb, xc, gs, gc, go, bc, dc, da);
      e = ref_add(xa, xb, xc);
      n_checks++;
      if (dc == 0 || {go, gc, gs} !== e) begin
        n_fail++;
        $display("FAIL rand[%0d]: a=%h b=%h cin=%b got ovf=%b cout=%b sum=%h (done_cyc=%0d) expected ovf=%b cout=%b sum=%h",
                 k, xa, xb, xc, go, gc, gs, dc, e[W+1], e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] a1, b1, a2, b2; logic c1, c2;
    logic [W+1:0] r1, r2, e1, e2;
    int ndone, dc1, dc2;
    a1 = $urandom(); b1 = $urandom(); c1 = 1'b1;
    a2 = $urandom(); b2 = $urandom(); c2 = 1'b0;
    e1 = ref_add(a1, b1, c1); e2 = ref_add(a2, b2, c2);
    r1 = '0; r2 = '0; ndone = 0; dc1 = 0; dc2 = 0;
    a = a1; b = b1; cin = c1; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin a = a2; b = b2; cin = c2; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin r1 = {overflow, cout, sum}; dc1 = i; end
        else            begin r2 = {overflow, cout, sum}; dc2 = i; end
      end
      // Drop the request once the re-started operation is running.
      if (ndone >= 1 && busy) start = 1'b0;
    end
    start = 1'b0;
    n_checks++; if (ndone !== 2) begin n_fail++; $display("FAIL held_done_count: got %0d expected 2", ndone); end
    n_checks++; if (dc1 !== NBYTES + 1) begin n_fail++; $display("FAIL held_first_latency: got %0d expected %0d", dc1, NBYTES + 1); end
    n_checks++; if (r1 !== e1) begin n_fail++; $display("FAIL held_first_result: got %h expected %h", r1, e1); end
    n_checks++; if (dc2 !== 2 * NBYTES + 3) begin n_fail++; $display("FAIL held_second_latency: got %0d expected %0d", dc2, 2 * NBYTES + 3); end
    n_checks++; if (r2 !== e2) begin n_fail++; $display("FAIL held_second_result: got %h expected %h", r2, e2); end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] gs; logic gc, go, da; int bc, dc, ndone;
    logic [W+1:0] e;
    // Leave a nonzero result with carry and overflow set beforehand.
    do_op(32'h80000000, 32'h80000000, 1'b1, gs, gc, go, bc, dc, da);
    a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);          // first RUN cycle
    start = 1'b0;
    @(negedge clk);          // second RUN cycle
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if ({done, cout, overflow} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got done/cout/ovf=%b expected 000", {done, cout, overflow}); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL midrst_sum: got %h expected 0", sum); end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", ndone); end
    do_op(32'h0000FFFF, 32'hFFFF0001, 1'b0, gs, gc, go, bc, dc, da);
    e = ref_add(32'h0000FFFF, 32'hFFFF0001, 1'b0);
    n_checks++; if (dc == 0 || {go, gc, gs} !== e) begin n_fail++; $display("FAIL midrst_next_op: got %h (done_cyc=%0d) expected %h", {go, gc, gs}, dc, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multibyte_add_seq
`default_nettype wire

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
Byte-serial multi-precision adder controller. It latches two NBYTES-wide operands and a carry-in on a start request. It then sequences one shared adder8Bit instance over the operands, least-significant byte first, chaining the carry through a register. When the last byte is done it presents the wide sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting datapath and the existing 8-bit adder, so wide additions reuse a single byte adder.

Parameters:
NBYTES, 4, operand width in bytes; legal range 1..16; operand width W = 8*NBYTES.
IDXW, derived as max(1, $clog2(NBYTES)), byte index counter width; not to be overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse/level; sampled only in IDLE.
cin  input  1  carry-in for byte 0; latched with start.
a  input  W  operand A; latched with start.
b  input  W  operand B; latched with start.
busy  output  1  high while bytes are being processed (state RUN).
done  output  1  one-cycle pulse; sum/cout/overflow are valid.
sum  output  W  result; holds its value until the next accepted start.
cout  output  1  carry out of the most significant byte.
overflow  output  1  two's-complement overflow of the W-bit add.

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, idx=0, carry_reg=0, operand registers=0.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - An operation in progress is abandoned; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k: a_reg<=a, b_reg<=b, carry_reg<=cin, idx<=0, state<=RUN.
  - Otherwise remain in IDLE.
- RUN:
  - The adder8Bit instance is driven with Cin=carry_reg, A=a_reg[8*idx +: 8], B=b_reg[8*idx +: 8].
  - Each edge: sum[8*idx +: 8]<=S, carry_reg<=Cout, idx<=idx+1.
  - At the edge processing idx=NBYTES-1: cout<=Cout, overflow<=(A[7]==B[7]) && (S[7]!=A[7]), state<=DONE, idx<=0.
- DONE:
  - done=1 for exactly one cycle; next edge state<=IDLE.
- Latency:
  - start sampled at edge k; bytes processed at edges k+1..k+NBYTES.
  - done is high in the cycle following edge k+NBYTES; back in IDLE after edge k+NBYTES+1.
  - Throughput: one operation per NBYTES+2 cycles.
- Outputs are registered: busy = (state==RUN), done = (state==DONE).
- start in RUN or DONE is ignored: no queueing, no effect on the operands being processed. The requester re-asserts start after done.
- a, b and cin may change freely after the start edge; only the latched copies are used.
- sum bytes update progressively during RUN. sum is valid only when done=1, and holds afterwards.
- NBYTES=1: a single RUN cycle; the idx compare is against 0; behaviour is otherwise identical.
- Arithmetic is modulo 2^W. cout is the true carry of a+b+cin. overflow is the signed overflow of the full-width add, computed from the top byte only.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - The byte-width constant BYTE_W=8.
- One sub-module: the existing adder8Bit, instantiated once, combinational, port order (Cin, A, B, Cout, S).
- The FSM, index counter, carry register and operand/result registers stay in multibyte_add_seq.

Test Plan:
- NBYTES=4, reset held 2 cycles then released -> busy=0, done=0, sum=0, cout=0, overflow=0. start with a=0x00000002, b=0x00000003, cin=0 -> busy high 4 cycles; done pulse 5 cycles after the start edge; sum=0x00000005, cout=0, overflow=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1, overflow=0. With cin=0 -> sum=0xFFFFFFFE, cout=1.
- Carry ripple across bytes: a=0x00FFFFFF, b=0x00000001, cin=0 -> sum=0x01000000, cout=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1, cout=0. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, overflow=1.
- start held high through RUN with a and b changed after the start edge -> exactly one done pulse; result uses the originally latched operands. Exactly one additional operation starts from IDLE because start is still high.
- Assert reset during the second RUN cycle -> all outputs 0 immediately (asynchronous). No done pulse. The next start runs to a correct result.
